// File: rtl/divisor_buf_pkg.sv
// Shared constants for the UART baud-rate divisor holding register.
package divisor_buf_pkg;

    localparam int DIV_W = 16;

    localparam logic [1:0] ADDR_DBL = 2'b10;
    localparam logic [1:0] ADDR_DBH = 2'b11;

    localparam logic [DIV_W-1:0] RESET_DIV_C = 16'h0000;

endpackage : divisor_buf_pkg

// File: rtl/divisor_buf.sv
// Byte-wide staging of the 16-bit baud divisor; the high-byte write commits atomically.
// Optional build macro DIVBUF_ZERO_GUARD_EN rejects commits of an all-zero divisor.
module divisor_buf
    import divisor_buf_pkg::*;
#(
    parameter logic [1:0]       LOW_ADDR  = ADDR_DBL,
    parameter logic [1:0]       HIGH_ADDR = ADDR_DBH,
    parameter logic [DIV_W-1:0] RESET_DIV = RESET_DIV_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       io_addr,
    input  logic             baud_write,
    input  logic [7:0]       data_in,
    output logic [DIV_W-1:0] div_buf,
    output logic             buf_rdy
);

    logic [DIV_W-1:0] div_buf_q, div_buf_d;
    logic             buf_rdy_q, buf_rdy_d;
    logic [7:0]       low_stage_q, low_stage_d;
    logic             low_seen_q, low_seen_d;
    logic [DIV_W-1:0] assembled;

    assign assembled = {data_in, low_stage_q};

    always_comb begin
        div_buf_d   = div_buf_q;
        buf_rdy_d   = buf_rdy_q;
        low_stage_d = low_stage_q;
        low_seen_d  = low_seen_q;

        if (baud_write) begin
            if (io_addr == LOW_ADDR) begin
                low_stage_d = data_in;
                low_seen_d  = 1'b1;
                buf_rdy_d   = 1'b0;
            end else if (io_addr == HIGH_ADDR) begin
                // A high write without a fresh low byte reuses whatever is staged.
                low_seen_d = 1'b0;
`ifdef DIVBUF_ZERO_GUARD_EN
                if (assembled == '0) begin
                    buf_rdy_d = 1'b0;
                end else begin
                    div_buf_d = assembled;
                    buf_rdy_d = 1'b1;
                end
`else
                div_buf_d = assembled;
                buf_rdy_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_buf_q   <= RESET_DIV;
            buf_rdy_q   <= 1'b0;
            low_stage_q <= 8'h00;
            low_seen_q  <= 1'b0;
        end else begin
            div_buf_q   <= div_buf_d;
            buf_rdy_q   <= buf_rdy_d;
            low_stage_q <= low_stage_d;
            low_seen_q  <= low_seen_d;
        end
    end

    assign div_buf = div_buf_q;
    assign buf_rdy = buf_rdy_q;

endmodule : divisor_buf

// File: tb/tb_divisor_buf.sv
// Vector-table bench for divisor_buf with a queue of expected results per edge.
module tb_divisor_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  io_addr;
    logic        baud_write;
    logic [7:0]  data_in;
    logic [15:0] div_buf;
    logic        buf_rdy;

    divisor_buf dut (
        .clk        (clk),
        .rst        (rst),
        .io_addr    (io_addr),
        .baud_write (baud_write),
        .data_in    (data_in),
        .div_buf    (div_buf),
        .buf_rdy    (buf_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [15:0] div;
        logic        rdy;
    } vec_t;

    typedef struct packed {
        logic [15:0] div;
        logic        rdy;
    } exp_t;

    localparam int NVEC = 18;

    vec_t vecs[NVEC];
    exp_t exp_q[$];
    int   n_applied = 0;
    int   n_miss    = 0;

    task automatic apply(input logic r, input logic we, input logic [1:0] a,
                         input logic [7:0] d, input logic [15:0] ediv,
                         input logic erdy, input string name);
        exp_t e;
        @(negedge clk);
        rst        = r;
        baud_write = we;
        io_addr    = a;
        data_in    = d;
        exp_q.push_back('{div: ediv, rdy: erdy});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_applied++;
        if (div_buf !== e.div || buf_rdy !== e.rdy) begin
            n_miss++;
            $display("FAIL %s: got div_buf=%h buf_rdy=%b, want div_buf=%h buf_rdy=%b",
                     name, div_buf, buf_rdy, e.div, e.rdy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        baud_write = 1'b0;
        io_addr    = 2'b00;
        data_in    = 8'h00;

        vecs[0]  = '{1'b1, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b10, 8'hAA, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b11, 8'h50, 16'h50AA, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 8'h0F, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 8'h50, 16'h500F, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 8'h34, 16'h500F, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b11, 8'h12, 16'h1234, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 8'hFF, 16'h1234, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 8'hFF, 16'h1234, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 8'hFF, 16'h1234, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'b11, 8'hFF, 16'h1234, 1'b1};
        // High without a new low: reuses staged 8'h34.
        vecs[13] = '{1'b0, 1'b1, 2'b11, 8'h56, 16'h5634, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 2'b11, 8'h77, 16'h0000, 1'b0};
        // Stage was cleared by reset, so low byte is 8'h00.
        vecs[15] = '{1'b0, 1'b1, 2'b11, 8'h9A, 16'h9A00, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 2'b10, 8'h00, 16'h9A00, 1'b0};
`ifdef DIVBUF_ZERO_GUARD_EN
        vecs[17] = '{1'b0, 1'b1, 2'b11, 8'h00, 16'h9A00, 1'b0};
`else
        vecs[17] = '{1'b0, 1'b1, 2'b11, 8'h00, 16'h0000, 1'b1};
`endif

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].data,
                  vecs[i].div, vecs[i].rdy, $sformatf("vec%0d", i));
        end

        // Re-establish a known committed value, then hold the strobe across edges.
`ifdef DIVBUF_ZERO_GUARD_EN
        apply(1'b0, 1'b1, 2'b10, 8'h11, 16'h9A00, 1'b0, "setup_low");
        apply(1'b0, 1'b1, 2'b11, 8'h22, 16'h2211, 1'b1, "setup_high");
`else
        apply(1'b0, 1'b1, 2'b10, 8'h11, 16'h0000, 1'b0, "setup_low");
        apply(1'b0, 1'b1, 2'b11, 8'h22, 16'h2211, 1'b1, "setup_high");
`endif
        for (int i = 0; i < 3; i++)
            apply(1'b0, 1'b1, 2'b10, 8'hC3, 16'h2211, 1'b0, $sformatf("hold_low%0d", i));
        for (int i = 0; i < 3; i++)
            apply(1'b0, 1'b1, 2'b11, 8'h3C, 16'h3CC3, 1'b1, $sformatf("hold_high%0d", i));

        // Reset dominates a simultaneous low write; stage must come back as zero.
        apply(1'b1, 1'b1, 2'b10, 8'h5A, 16'h0000, 1'b0, "rst_vs_low");
        apply(1'b0, 1'b1, 2'b11, 8'h01, 16'h0100, 1'b1, "after_rst_high");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule : tb_divisor_buf

// File: doc/divisor_buf.md
Name: divisor_buf

Overview:
- Holding register for the 16-bit UART baud-rate divisor, written one byte at a time over the 8-bit CPU I/O bus.
- Sits between the bus decoder and the baud-rate generator.
- Low byte is staged first; the high-byte write commits the full 16-bit value atomically and flags it ready, so the generator never sees a half-updated divisor.

Parameters:
- LOW_ADDR, 2'b10, io_addr value selecting the divisor low byte (DBL).
- HIGH_ADDR, 2'b11, io_addr value selecting the divisor high byte (DBH).
- RESET_DIV, 16'h0000, value loaded into div_buf on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- io_addr  input  2  I/O register address from the bus.
- baud_write  input  1  write strobe for divisor registers; sampled on each rising clk edge.
- data_in  input  8  write data byte.
- div_buf  output  16  committed divisor {high, low}, registered.
- buf_rdy  output  1  high while div_buf holds a complete, committed divisor.

Interface rule (already decided): one clock; reset is synchronous and active-high (clock port clk, reset port rst).

Behaviour:
- Internal state:
  - low_stage[7:0]: staged low byte.
  - low_seen: set when a low byte has been staged since the last commit or reset.
- Reset (rst=1 at posedge):
  - div_buf <= RESET_DIV; buf_rdy <= 0; low_stage <= 0; low_seen <= 0.
  - Reset dominates any simultaneous write.
- Low write (baud_write=1, io_addr==LOW_ADDR):
  - low_stage <= data_in; low_seen <= 1; buf_rdy <= 0.
  - div_buf unchanged.
- High write (baud_write=1, io_addr==HIGH_ADDR):
  - div_buf <= {data_in, low_stage}; buf_rdy <= 1; low_seen <= 0.
  - A high write with no preceding low write reuses the current low_stage. Its reset value is 0, or the last staged byte.
- A write is taken on every rising edge where baud_write=1. Holding baud_write high across edges rewrites the same register; the result is idempotent.
- baud_write=1 with io_addr 2'b00/2'b01: ignored, no state change.
- baud_write=0: all state holds.
- Latency: div_buf and buf_rdy change on the edge that samples the high-byte write (one cycle, registered). No combinational path from inputs to outputs.
- buf_rdy stays high until the next low write or reset.
- div_buf keeps its last committed value while a new low byte is staged.

Optional Feature:
- Macro DIVBUF_ZERO_GUARD_EN.
- Defined: a high write whose assembled value {data_in, low_stage} equals 16'h0000 is rejected. div_buf is unchanged, buf_rdy <= 0, and low_seen is cleared.
- Undefined: zero is committed like any other value and buf_rdy <= 1.

Decomposition:
- Package divisor_buf_pkg holds:
  - the address constants (ADDR_DBL=2'b10, ADDR_DBH=2'b11);
  - localparam DIV_W=16;
  - the reset divisor constant.
- Single flat module; no sub-module needed. Staging and commit logic is one always block.

Test Plan:
1. Reset 2 cycles -> div_buf=16'h0000, buf_rdy=0.
2. Write LOW 8'hAA then HIGH 8'h50 on consecutive edges:
   - after LOW: div_buf=16'h0000, buf_rdy=0;
   - after HIGH: div_buf=16'h50AA, buf_rdy=1.
3. From state 2, assert rst one cycle -> div_buf=16'h0000, buf_rdy=0. Then LOW 8'h0F, HIGH 8'h50 -> div_buf=16'h500F, buf_rdy=1.
4. From state 3, write LOW 8'h34 -> buf_rdy=0, div_buf still 16'h500F. Then HIGH 8'h12 -> div_buf=16'h1234, buf_rdy=1.
5. baud_write=1 with io_addr=2'b00 and 2'b01, data_in=8'hFF -> no change to div_buf or buf_rdy. Same addresses with baud_write=0 and io_addr=LOW/HIGH -> no change.
6. rst=1 in the same cycle as a HIGH write of 8'h77 -> div_buf=16'h0000, buf_rdy=0. With DIVBUF_ZERO_GUARD_EN defined, after reset write LOW 8'h00 then HIGH 8'h00 -> div_buf stays 16'h0000, buf_rdy=0.
